// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: combinational ROM port plus the valid/ready link to decode.
// The master modport is the fetch controller, the slave is the ROM/decode side.
interface inst_fetch_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ce;
  logic [31:0]       rom_inst;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_pc;
  logic [31:0]       if_inst;

  modport master (
    output rom_addr, rom_ce, if_valid, if_pc, if_inst,
    input  rom_inst, if_ready
  );

  modport slave (
    input  rom_addr, rom_ce, if_valid, if_pc, if_inst,
    output rom_inst, if_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational ROM and queues
// fetched words in a small in-order buffer for decode; handles branch redirect and illegal-PC fault.
module inst_fetch_ctrl #(
  parameter int          ADDR_W     = 6,
  parameter logic [31:0] BOOT_PC    = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_target_i,
  inst_fetch_ctrl_if.master   bus,
  output logic                running_o,
  output logic                fault_o,
  output logic [31:0]         fault_pc_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t        state, state_next;
  logic [31:0]   pc, pc_next;
  logic [31:0]   fault_pc, fault_pc_next;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   inst_mem [FIFO_DEPTH];

  logic pc_ok, fetch_en, pop, flush, head_valid;

  assign pc_ok      = (pc[1:0] == 2'b00) && (pc[31:ADDR_W+2] == '0);
  assign head_valid = (count != '0);
  assign pop        = head_valid && bus.if_ready;
  // Fetch gating looks only at the registered count so if_ready never reaches rom_ce.
  assign fetch_en   = (state == RUN) && !branch_i && pc_ok && (count < DEPTH_C);

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    fault_pc_next = fault_pc;
    flush         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          state_next = RUN;
          pc_next    = BOOT_PC;
          flush      = 1'b1;
        end
      end
      RUN: begin
        if (branch_i) begin
          pc_next = branch_target_i;
          flush   = 1'b1;
        end else if (!pc_ok) begin
          state_next    = FAULT;
          fault_pc_next = pc;
        end else if (fetch_en) begin
          pc_next = pc + 32'd4;
        end
      end
      FAULT: begin
        if (start_i) begin
          state_next    = RUN;
          pc_next       = BOOT_PC;
          fault_pc_next = '0;
          flush         = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= BOOT_PC;
      fault_pc <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      fault_pc <= fault_pc_next;
    end
  end

  // A flush outranks any same-cycle push or pop; a popped head still counts as delivered.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fetch_en) begin
        pc_mem[wr_ptr]   <= pc;
        inst_mem[wr_ptr] <= bus.rom_inst;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({fetch_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.rom_ce   = fetch_en;
  assign bus.rom_addr = fetch_en ? pc[ADDR_W+1:2] : '0;
  assign bus.if_valid = head_valid;
  assign bus.if_pc    = head_valid ? pc_mem[rd_ptr]   : 32'h0;
  assign bus.if_inst  = head_valid ? inst_mem[rd_ptr] : 32'h0;
  assign running_o    = (state == RUN);
  assign fault_o      = (state == FAULT);
  assign fault_pc_o   = fault_pc;

endmodule
